// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
//
// Parallel-to-serial stage that feeds the "1101" Mealy sequence detector.
// Words arrive over a valid/ready handshake and are driven one bit at a time
// onto serial_out. A one-word holding buffer lets consecutive words stream
// with no idle gap, so a pattern that straddles two words is still seen
// downstream.
//
// Parameters:
//   DATA_WIDTH  bits per word (>= 2)
//   MSB_FIRST   1: bit DATA_WIDTH-1 sent first (shift left)
//               0: bit 0 sent first (shift right)
//   BIT_PERIOD  clock cycles each bit is held on serial_out (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   load_valid  upstream word available
//   load_data   word to serialize
//   load_ready  block can accept a word this cycle (= buffer not full)
//   serial_out  serial bit to the detector input, idles at 0
//   bit_strobe  high in the first cycle of each new bit
//   busy        a word is being shifted
//   word_done   one-cycle pulse in the final cycle of a word's last bit
// -----------------------------------------------------------------------------
module serial_word_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int BIT_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  serial_out,
    output logic                  bit_strobe,
    output logic                  busy,
    output logic                  word_done
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(BIT_PERIOD + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] LAST_PER = PW'(BIT_PERIOD - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [BW-1:0]         r_bit;
    logic [PW-1:0]         r_per;

    logic                  w_xfer;
    logic                  w_last_cycle;
    logic                  w_last_bit;
    logic                  w_word_end;
    logic [DATA_WIDTH-1:0] w_shifted;

    // Handshake and end-of-bit / end-of-word qualifiers, all from registered
    // state except w_xfer, which also needs load_valid.
    always_comb begin
        w_xfer       = load_valid && !r_buf_full;
        w_last_cycle = (r_per == LAST_PER);
        w_last_bit   = (r_bit == LAST_BIT);
        w_word_end   = (r_state == SHIFT) && w_last_bit && w_last_cycle;
    end

    always_comb begin
        w_shifted = '0;
        if (MSB_FIRST != 0) begin
            w_shifted = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_bit      <= '0;
            r_per      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_shift <= load_data;
                        r_bit   <= '0;
                        r_per   <= '0;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_word_end) begin
                        // Next word comes from the buffer first, else a
                        // same-edge transfer bypasses the buffer entirely.
                        r_per <= '0;
                        r_bit <= '0;
                        if (r_buf_full) begin
                            r_shift    <= r_buf;
                            r_buf_full <= 1'b0;
                        end else if (w_xfer) begin
                            r_shift <= load_data;
                        end else begin
                            r_shift <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_last_cycle) begin
                            r_per   <= '0;
                            r_bit   <= r_bit + BW'(1);
                            r_shift <= w_shifted;
                        end else begin
                            r_per <= r_per + PW'(1);
                        end
                        if (w_xfer) begin
                            r_buf      <= load_data;
                            r_buf_full <= 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        load_ready = !r_buf_full;
        busy       = (r_state == SHIFT);
        bit_strobe = (r_state == SHIFT) && (r_per == '0);
        word_done  = w_word_end;
        serial_out = 1'b0;
        if (r_state == SHIFT) begin
            serial_out = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];
        end
    end

endmodule
